// File: rtl/soc_io.sv
// soc_io: LED register plus an 8N1 UART transmitter behind a four-word IO page.
// Optional macro UART_FIFO_EN adds a FIFO_DEPTH-entry TX queue ahead of the transmitter.
module soc_io #(
  parameter int LED_W        = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             io_en,
  input  logic [1:0]       io_addr,
  input  logic [31:0]      io_wdata,
  input  logic             io_wstrb,
  input  logic             io_rstrb,
  output logic [31:0]      io_rdata,
  output logic [LED_W-1:0] LED,
  output logic             TXD
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  tx_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] baud_r, baud_nxt_s;
  logic [2:0]       bit_r, bit_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             txd_r, txd_nxt_s;
  logic [LED_W-1:0] led_r;
  logic [31:0]      rdata_r, rdata_nxt_s, led_ext_s;
  logic             ovf_r, ovf_nxt_s;
  logic             wr_s, rd_s, wr_led_s, wr_data_s, wr_stat_s;
  logic             busy_s, full_s, load_avail_s, load_take_s;
  logic [7:0]       load_byte_s;
  logic             unused_s;

  assign wr_s      = io_en & io_wstrb;
  assign rd_s      = io_en & io_rstrb;
  assign wr_led_s  = wr_s & (io_addr == 2'd0);
  assign wr_data_s = wr_s & (io_addr == 2'd1);
  assign wr_stat_s = wr_s & (io_addr == 2'd2);

`ifdef UART_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r, rptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;

  // Fullness uses the pre-edge count, so a same-cycle dequeue never frees a slot early.
  assign full_s       = (count_r == (PTR_W+1)'(FIFO_DEPTH));
  assign push_s       = wr_data_s & ~full_s;
  assign load_avail_s = (count_r != '0);
  assign load_byte_s  = fifo_mem_r[rptr_r];
  assign busy_s       = (state_r != ST_IDLE) | load_avail_s;
  assign unused_s     = ^io_wdata;

  // Queue storage; entries are only read when count_r says they are valid
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wptr_r] <= io_wdata[7:0];
    end
  end

  // Queue pointers wrap naturally because the depth is a power of two
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (load_take_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(load_take_s);
    end
  end
`else
  // Without a queue the write itself feeds the shift register, and only while idle.
  assign busy_s       = (state_r != ST_IDLE);
  assign full_s       = busy_s;
  assign load_avail_s = wr_data_s & ~full_s;
  assign load_byte_s  = io_wdata[7:0];
  assign unused_s     = ^{io_wdata, load_take_s};
`endif

  // TX sequencing: next state, baud/bit counters, shift register and next TXD level
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    load_take_s = 1'b0;
    txd_nxt_s   = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (load_avail_s) begin
          state_nxt_s = ST_START;
          shift_nxt_s = load_byte_s;
          baud_nxt_s  = '0;
          bit_nxt_s   = 3'd0;
          load_take_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          state_nxt_s = ST_DATA;
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_nxt_s   = 3'd0;
            state_nxt_s = ST_STOP;
          end else begin
            bit_nxt_s = bit_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s = '0;
          if (load_avail_s) begin
            state_nxt_s = ST_START;
            shift_nxt_s = load_byte_s;
            bit_nxt_s   = 3'd0;
            load_take_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = '0;
        bit_nxt_s   = 3'd0;
      end
    endcase

    // TXD is derived from the next state so the line changes on the same edge as the FSM.
    case (state_nxt_s)
      ST_START: txd_nxt_s = 1'b0;
      ST_DATA:  txd_nxt_s = shift_nxt_s[0];
      default:  txd_nxt_s = 1'b1;
    endcase
  end

  // TX state register; reset aborts any frame in progress
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      txd_r   <= txd_nxt_s;
    end
  end

  // Read mux sees pre-write register values; overflow set has priority over clear
  always_comb begin
    led_ext_s              = 32'd0;
    led_ext_s[LED_W-1:0]   = led_r;
    rdata_nxt_s            = rdata_r;
    ovf_nxt_s              = ovf_r;
    if (rd_s) begin
      case (io_addr)
        2'd0:    rdata_nxt_s = led_ext_s;
        2'd2:    rdata_nxt_s = {29'd0, ovf_r, full_s, busy_s};
        default: rdata_nxt_s = 32'd0;
      endcase
    end else begin
      rdata_nxt_s = rdata_r;
    end
    if (wr_data_s & full_s) begin
      ovf_nxt_s = 1'b1;
    end else if (wr_stat_s & io_wdata[2]) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Bus-visible registers: LED, held read data, sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_r   <= '0;
      rdata_r <= 32'd0;
      ovf_r   <= 1'b0;
    end else begin
      if (wr_led_s) begin
        led_r <= io_wdata[LED_W-1:0];
      end
      rdata_r <= rdata_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign io_rdata = rdata_r;
  assign LED      = led_r;
  assign TXD      = txd_r;

endmodule

// File: tb/tb_soc_io.sv
// Self-checking bench for soc_io: directed steps plus a random phase, all checked
// against a frame-level reference model (queue of bytes, cycle index within a frame).
module tb_soc_io;
  localparam int LED_W = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_FIFO_EN
  localparam int START_LAT = 1;
`else
  localparam int START_LAT = 0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             io_en = 1'b0;
  logic [1:0]       io_addr = 2'd0;
  logic [31:0]      io_wdata = 32'd0;
  logic             io_wstrb = 1'b0;
  logic             io_rstrb = 1'b0;
  logic [31:0]      io_rdata;
  logic [LED_W-1:0] LED;
  logic             TXD;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  soc_io #(.LED_W(LED_W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .io_en(io_en), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_wstrb(io_wstrb), .io_rstrb(io_rstrb), .io_rdata(io_rdata), .LED(LED), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending bytes, the frame on the wire and its elapsed cycle count.
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_rdata;
  logic             m_ovf;
  logic [7:0]       m_q[$];
  logic             m_act;
  logic [7:0]       m_byte;
  int               m_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy();
    return m_act || (m_q.size() != 0);
  endfunction

  function automatic logic m_full();
`ifdef UART_FIFO_EN
    return m_q.size() == DEPTH;
`else
    return m_busy();
`endif
  endfunction

  function automatic logic m_txd();
    int slot;
    if (!m_act) return 1'b1;
    slot = m_k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  task automatic model_reset();
    m_led = '0; m_rdata = 32'd0; m_ovf = 1'b0; m_q.delete();
    m_act = 1'b0; m_byte = 8'd0; m_k = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic wr, rd, full0, busy0;
    wr = io_en & io_wstrb;
    rd = io_en & io_rstrb;
    busy0 = m_busy();
    full0 = m_full();
    if (rd) begin
      if (io_addr == 2'd0) m_rdata = 32'(m_led);
      else if (io_addr == 2'd2) m_rdata = {29'd0, m_ovf, full0, busy0};
      else m_rdata = 32'd0;
    end
    if (m_act) begin
      m_k++;
      if (m_k == 10 * CPB) begin
        m_act = 1'b0;
        if (m_q.size() != 0) begin
          m_byte = m_q.pop_front(); m_act = 1'b1; m_k = 0;
        end
      end
    end else if (m_q.size() != 0) begin
      m_byte = m_q.pop_front(); m_act = 1'b1; m_k = 0;
    end
    if (wr) begin
      if (io_addr == 2'd0) m_led = io_wdata[LED_W-1:0];
      else if (io_addr == 2'd1) begin
        if (full0) m_ovf = 1'b1;
        else begin
`ifdef UART_FIFO_EN
          m_q.push_back(io_wdata[7:0]);
`else
          m_byte = io_wdata[7:0]; m_act = 1'b1; m_k = 0;
`endif
        end
      end else if (io_addr == 2'd2 && io_wdata[2]) m_ovf = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    check("txd", 32'(TXD), 32'(m_txd()));
    check("led", 32'(LED), 32'(m_led));
    check("rdata", io_rdata, m_rdata);
  endtask

  task automatic access(input logic [1:0] a, input logic [31:0] d, input logic w, input logic r);
    io_en = 1'b1; io_addr = a; io_wdata = d; io_wstrb = w; io_rstrb = r;
    tick();
    io_en = 1'b0; io_wstrb = 1'b0; io_rstrb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_led", 32'(LED), 32'd0);
    check("rst_rdata", io_rdata, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    model_reset();
    async_reset();

    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("status_after_reset", io_rdata, 32'h0);
    access(2'd0, 32'h1A5, 1'b1, 1'b0);
    check("led_write", 32'(LED), 32'hA5);
    access(2'd0, 32'd0, 1'b0, 1'b1);
    check("led_read", io_rdata, 32'h000000A5);
    idle(2);
    check("rdata_held", io_rdata, 32'hA5);
    access(2'd0, 32'h3C, 1'b1, 1'b1);
    check("wr_rd_pre_value", io_rdata, 32'hA5);
    check("wr_rd_led", 32'(LED), 32'h3C);
    access(2'd3, 32'hFF, 1'b1, 1'b0);
    check("off3_write_ignored", 32'(LED), 32'h3C);
    access(2'd3, 32'd0, 1'b0, 1'b1);
    check("off3_read", io_rdata, 32'd0);
    access(2'd1, 32'd0, 1'b0, 1'b1);
    check("data_read", io_rdata, 32'd0);

    // Single 0x55 frame, status polled every cycle.
    access(2'd1, 32'h55, 1'b1, 1'b0);
    for (int j = 1; j <= 44; j++) begin
      access(2'd2, 32'd0, 1'b0, 1'b1);
      if (j == 40 + START_LAT) check("busy_last_cycle", 32'(io_rdata[0]), 32'd1);
      if (j == 41 + START_LAT) check("busy_cleared", 32'(io_rdata[0]), 32'd0);
    end
    check("status_after_frame", io_rdata, 32'h0);

    // Two writes on consecutive cycles.
    access(2'd1, 32'h11, 1'b1, 1'b0);
    access(2'd1, 32'h22, 1'b1, 1'b0);
    idle(90);
    access(2'd2, 32'd0, 1'b0, 1'b1);
`ifdef UART_FIFO_EN
    check("two_writes_status", io_rdata, 32'h0);
`else
    check("two_writes_status", io_rdata, 32'h4);
`endif
    access(2'd2, 32'h4, 1'b1, 1'b0);
    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("ovf_cleared", io_rdata, 32'h0);

`ifdef UART_FIFO_EN
    for (int i = 1; i <= 6; i++) access(2'd1, 32'(i), 1'b1, 1'b0);
    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("fifo_full_status", io_rdata, 32'h7);
    idle(5 * 10 * CPB + 10);
    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("fifo_drained_status", io_rdata, 32'h4);
    access(2'd2, 32'h4, 1'b1, 1'b0);
    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("fifo_ovf_cleared", io_rdata, 32'h0);
`endif

    // Random bus traffic against the model.
    for (int i = 0; i < 400; i++) begin
      io_en    = ($urandom_range(0, 3) != 0);
      io_addr  = 2'($urandom_range(0, 3));
      io_wdata = $urandom;
      io_wstrb = ($urandom_range(0, 5) == 0);
      io_rstrb = 1'($urandom_range(0, 1));
      tick();
    end
    io_en = 1'b0; io_wstrb = 1'b0; io_rstrb = 1'b0;
    idle(250);

    // Reset in the middle of a 0xFF frame.
    access(2'd1, 32'hFF, 1'b1, 1'b0);
    idle(3 * CPB);
    async_reset();
    access(2'd2, 32'd0, 1'b0, 1'b1);
    check("status_after_mid_reset", io_rdata, 32'h0);
    idle(50);

    // Reset during the start bit, where TXD is low.
    access(2'd1, 32'hFF, 1'b1, 1'b0);
    idle(1);
    check("start_bit_low", 32'(TXD), 32'd0);
    async_reset();
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_io.md
SOC_IO -- requirements
Module: soc_io

Interface
REQ-001 Parameter: LED_W, default 8, width of the LED output register (1..32).
REQ-002 Parameter: CLKS_PER_BIT, default 104, CLK cycles per UART bit (>=2).
REQ-003 Parameter: FIFO_DEPTH, default 4, TX FIFO entries; power of 2, >=2; used only when UART_FIFO_EN is defined.
REQ-004 Port: CLK  in  1  system clock; all state changes on the rising edge.
REQ-005 Port: RST  in  1  reset, asynchronous, active-high.
REQ-006 Port: io_en  in  1  bus access targets the IO page (address decoded by the SOC).
REQ-007 Port: io_addr  in  2  word offset: 0=LED, 1=UART_DATA, 2=UART_STATUS, 3=reserved.
REQ-008 Port: io_wdata  in  32  write data.
REQ-009 Port: io_wstrb  in  1  write strobe, single cycle.
REQ-010 Port: io_rstrb  in  1  read strobe, single cycle.
REQ-011 Port: io_rdata  out  32  registered read data.
REQ-012 Port: LED  out  LED_W  LED register.
REQ-013 Port: TXD  out  1  UART serial output, 8N1, idle high.

Function
REQ-014 Writes with io_en&io_wstrb take effect at the next rising edge; reads with io_en&io_rstrb present io_rdata one cycle later, held until the next read.
REQ-015 LED write loads io_wdata[LED_W-1:0]; LED read returns LED zero-extended.
REQ-016 UART_DATA write enqueues io_wdata[7:0]; UART_DATA read returns 0.
REQ-017 UART_STATUS read: bit0 busy (TX FSM not IDLE or queue non-empty), bit1 full (write would be dropped), bit2 overflow (sticky), other bits 0.
REQ-018 UART_STATUS write with io_wdata[2]=1 clears overflow; other bits ignored.
REQ-019 UART_DATA write while full drops the byte and sets overflow; fullness is evaluated before any same-cycle dequeue.
REQ-020 Same-cycle overflow set and clear: set wins.
REQ-021 Offset 3: writes ignored, reads return 0.
REQ-022 Simultaneous io_wstrb and io_rstrb: write performed; read returns the pre-write value.
REQ-023 TX FSM states IDLE, START, DATA, STOP; baud counter counts 0..CLKS_PER_BIT-1; a bit counter counts 0..7.
REQ-024 IDLE: TXD=1; a queued byte moves to START on the next edge, loading the shift register.
REQ-025 START: TXD=0 for CLKS_PER_BIT cycles; then DATA.
REQ-026 DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; then STOP.
REQ-027 STOP: TXD=1 for CLKS_PER_BIT cycles; then START if another byte is queued (back-to-back, no idle gap), else IDLE.
REQ-028 One frame = 10*CLKS_PER_BIT cycles; TXD is a registered output (glitch-free).

Reset
REQ-029 RST asserted: LED=0, io_rdata=0, TXD=1, FSM=IDLE, counters=0, queue empty, overflow=0, all immediately and without waiting for CLK.
REQ-030 RST during a frame aborts it; TXD returns high; the partial byte is discarded.
REQ-031 After RST deasserts, first access is accepted on the first rising edge.

Configuration
REQ-032 Macro UART_FIFO_EN defined: queue is a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers; full = FIFO_DEPTH entries stored; the byte in flight is not counted.
REQ-033 UART_FIFO_EN undefined: no FIFO; a write is accepted only when FSM is IDLE and loads the shift register directly; full = busy; FIFO_DEPTH ignored.

Verification
REQ-034 CLKS_PER_BIT=4; write 0x55 to UART_DATA -> TXD 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4; busy clears 40 cycles after START begins.
REQ-035 Write LED=0x1A5, LED_W=8 -> LED=0xA5 next cycle; read LED -> io_rdata=0x000000A5 one cycle after io_rstrb.
REQ-036 UART_FIFO_EN, FIFO_DEPTH=4: 6 back-to-back writes 0x01..0x06 -> 0x01 in flight, 0x02..0x05 queued, 0x06 dropped, status=0x7; frames sent contiguously without idle gap.
REQ-037 After REQ-036 drains: status=0x4; write UART_STATUS 0x4 -> status read 0x0.
REQ-038 Assert RST mid-DATA of 0xFF -> TXD=1 asynchronously, status reads 0x0 after release, no further frame transmitted.
REQ-039 UART_FIFO_EN undefined: write 0x11 then 0x22 next cycle -> only 0x11 sent, overflow=1.
